// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared types and constants for the program memory controller
package prog_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // RV32I "addi x0, x0, 0", returned for any rejected fetch
    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
    localparam int          MEM_BYTES_DEF = 1024;

endpackage

// File: rtl/prog_mem_bank.sv
// rtl/prog_mem_bank.sv - byte-wide program store, one byte write port, one aligned word read port
//
// Ports:
//   clk, rst       clock; rst clears only the read data register, never the store
//   we/waddr/wdata synchronous byte write
//   re/raddr       synchronous little-endian word read; raddr[1:0] is ignored
//   rdata          registered word, holds its value while re is low
module prog_mem_bank import prog_mem_pkg::*; #(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [7:0]        mem [MEM_BYTES];
    logic [ADDR_W-1:0] a0, a1, a2, a3;

    assign a0 = {raddr[ADDR_W-1:2], 2'd0};
    assign a1 = {raddr[ADDR_W-1:2], 2'd1};
    assign a2 = {raddr[ADDR_W-1:2], 2'd2};
    assign a3 = {raddr[ADDR_W-1:2], 2'd3};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= {mem[a3], mem[a2], mem[a1], mem[a0]};
        end
    end

endmodule

// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - program store sequencer between the boot loader stream and core fetch
//
// Build option: PROG_MEM_CLEAR_EN - zero the whole store (one byte per cycle) after
// reset and after every reload, before accepting loader bytes.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ld_valid/ld_data/ld_last       loader byte stream in
//   ld_ready                       loader byte accepted this cycle (LOAD only)
//   reload_req                     pulse in RUN: abandon RUN and start a new load
//   fetch_req/pc                   core fetch request and byte address
//   instruction/fetch_valid        registered fetch result, valid one cycle after request
//   fetch_err                      last accepted fetch was misaligned or out of range
//   core_stall                     core held while no program is running
//   load_ovf                       image filled the store without ld_last
//   load_bytes                     bytes written by the current/last load
module prog_mem_ctrl import prog_mem_pkg::*; #(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload_req,
    input  logic              fetch_req,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              fetch_valid,
    output logic              fetch_err,
    output logic              core_stall,
    output logic              load_ovf,
    output logic [ADDR_W:0]   load_bytes
);

`ifdef PROG_MEM_CLEAR_EN
    localparam state_t START_ST = CLEAR;
`else
    localparam state_t START_ST = LOAD;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic              ptr_last;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              fetch_acc;
    logic              fetch_ok;
    logic [31:0]       mem_rdata;

    assign ptr_last   = (wr_ptr == ADDR_W'(MEM_BYTES - 1));
    // Full 32-bit compare so any upper pc bit makes the fetch out of range
    assign fetch_ok   = (pc[1:0] == 2'b00) && (pc <= 32'(MEM_BYTES - 4));
    assign core_stall = (state != RUN);
    // fetch_err and the bank word both hold between fetches, so the mux output holds too
    assign instruction = fetch_err ? NOP_INSN : mem_rdata;

    always_comb begin
        state_n   = state;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        fetch_acc = 1'b0;
        case (state)
`ifdef PROG_MEM_CLEAR_EN
            CLEAR: begin
                mem_we = 1'b1;
                if (ptr_last) begin
                    state_n = LOAD;
                end
            end
`endif
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    if (ld_last || ptr_last) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (reload_req) begin
                    state_n = START_ST;
                end else begin
                    fetch_acc = fetch_req;
                end
            end
            default: state_n = START_ST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= START_ST;
            wr_ptr      <= '0;
            load_bytes  <= '0;
            load_ovf    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_valid <= fetch_acc;
            if (fetch_acc) begin
                fetch_err <= !fetch_ok;
            end
            // Pointer doubles as the clear address; it wraps to 0 on leaving CLEAR
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == LOAD && mem_we) begin
                load_bytes <= load_bytes + 1'b1;
                if (!ld_last && ptr_last) begin
                    load_ovf <= 1'b1;
                end
            end
            if (state == RUN && reload_req) begin
                wr_ptr     <= '0;
                load_bytes <= '0;
                load_ovf   <= 1'b0;
            end
        end
    end

    prog_mem_bank #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (mem_wdata),
        .re    (fetch_acc && fetch_ok),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - self-checking bench for prog_mem_ctrl against a byte-array reference model
module tb_prog_mem_ctrl;
    import prog_mem_pkg::*;

    localparam int MB = 64;
    localparam int AW = 6;
`ifdef PROG_MEM_CLEAR_EN
    localparam int CLEAR_CYC = MB;
`else
    localparam int CLEAR_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, ld_valid, ld_last, ld_ready, reload_req, fetch_req;
    logic          fetch_valid, fetch_err, core_stall, load_ovf;
    logic [7:0]    ld_data;
    logic [31:0]   pc, instruction;
    logic [AW:0]   load_bytes;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    mdl_mem [MB];
    logic [31:0]   last_insn;
    logic          last_err;

    prog_mem_ctrl #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .reload_req(reload_req), .fetch_req(fetch_req), .pc(pc),
        .instruction(instruction), .fetch_valid(fetch_valid), .fetch_err(fetch_err),
        .core_stall(core_stall), .load_ovf(load_ovf), .load_bytes(load_bytes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!ld_ready && cnt < MB + 8) begin
            cnt++;
            tick();
        end
        check({tag, "_clear_cycles"}, cnt, CLEAR_CYC);
`ifdef PROG_MEM_CLEAR_EN
        for (int i = 0; i < MB; i++) mdl_mem[i] = 8'h00;
`endif
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; ld_valid = 0; ld_last = 0; ld_data = 0;
        reload_req = 0; fetch_req = 0; pc = 0;
        tick();
        rst = 1'b0;
        check({tag, "_stall"}, core_stall, 1);
        check({tag, "_fv"}, fetch_valid, 0);
        check({tag, "_err"}, fetch_err, 0);
        check({tag, "_insn"}, instruction, 0);
        check({tag, "_ovf"}, load_ovf, 0);
        check({tag, "_lbytes"}, load_bytes, 0);
        check({tag, "_ready"}, ld_ready, (CLEAR_CYC == 0) ? 1 : 0);
        last_insn = 32'h0;
        last_err  = 1'b0;
        wait_ready(tag);
    endtask

    // Byte stream with random idle gaps; stray fetch/reload/ld_last during gaps must be ignored
    task automatic load_image(input logic [7:0] img [$], input bit with_last,
                              input bit partial, input string tag);
        for (int i = 0; i < img.size(); i++) begin
            while ($urandom_range(0, 3) == 0) begin
                ld_valid = 0; ld_last = 1'($urandom); fetch_req = 1'($urandom);
                reload_req = 1'($urandom); pc = 0;
                tick();
                check({tag, "_gap_fv"}, fetch_valid, 0);
            end
            fetch_req = 0; reload_req = 0;
            check({tag, "_rdy"}, ld_ready, 1);
            ld_valid = 1; ld_data = img[i];
            ld_last  = with_last && (i == img.size() - 1);
            tick();
            mdl_mem[i] = img[i];
        end
        ld_valid = 0; ld_last = 0;
        if (!partial) begin
            check({tag, "_stall"}, core_stall, 0);
            check({tag, "_rdy_low"}, ld_ready, 0);
            check({tag, "_lbytes"}, load_bytes, img.size());
            check({tag, "_ovf"}, load_ovf, (!with_last && img.size() == MB) ? 1 : 0);
        end
    endtask

    // Leaves fetch_req high so consecutive calls form back-to-back requests
    task automatic fetch_one(input logic [31:0] a, input string tag);
        logic        ok;
        logic [31:0] exp;
        fetch_req = 1; pc = a;
        tick();
        ok  = (a % 4 == 0) && (a + 4 <= MB);
        exp = ok ? {mdl_mem[a + 3], mdl_mem[a + 2], mdl_mem[a + 1], mdl_mem[a]} : NOP_INSN;
        check({tag, "_fv"}, fetch_valid, 1);
        check({tag, "_err"}, fetch_err, !ok);
        check({tag, "_insn"}, instruction, exp);
        last_insn = exp;
        last_err  = !ok;
    endtask

    task automatic fetch_idle(input string tag);
        fetch_req = 0; pc = $urandom;
        tick();
        check({tag, "_fv"}, fetch_valid, 0);
        check({tag, "_hold"}, instruction, last_insn);
        check({tag, "_errhold"}, fetch_err, last_err);
    endtask

    task automatic do_reload(input bit with_fetch, input string tag);
        reload_req = 1; fetch_req = with_fetch; pc = 0;
        tick();
        reload_req = 0; fetch_req = 0;
        check({tag, "_fv"}, fetch_valid, 0);
        check({tag, "_stall"}, core_stall, 1);
        check({tag, "_lbytes"}, load_bytes, 0);
        check({tag, "_ovf"}, load_ovf, 0);
        check({tag, "_hold"}, instruction, last_insn);
        wait_ready(tag);
    endtask

    function automatic logic [31:0] rand_pc(input int n);
        case ($urandom_range(0, 4))
            0:       return MB;
            1:       return ($urandom_range(0, n / 4 - 1) * 4) + $urandom_range(1, 3);
            2:       return $urandom | 32'h8000_0000;
            default: return $urandom_range(0, n / 4 - 1) * 4;
        endcase
    endfunction

    initial begin
        logic [7:0] img [$];
        int         n;

        do_reset("rst0");

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_image(img, 1, 0, "boot");
        fetch_one(0, "f_pc0");
        check("f_pc0_const", instruction, 32'h0000_0013);
        fetch_one(4, "f_pc4");
        check("f_pc4_const", instruction, 32'h0010_0093);
        fetch_one(2, "f_mis");
        fetch_one(MB, "f_oor");
        fetch_one(32'h8000_0000, "f_hibit");
        fetch_one(4, "f_clr_err");
        fetch_idle("idle0");

        do_reload(1, "rl0");

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(4, MB - 1);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            load_image(img, 1, 0, "rnd_ld");
            for (int k = 0; k < 6; k++) fetch_one(rand_pc(n), "rnd_f");
            fetch_idle("rnd_idle");
            do_reload(1'($urandom), "rnd_rl");
        end

        img.delete();
        for (int i = 0; i < MB; i++) img.push_back(8'($urandom));
        load_image(img, 0, 0, "ovf");
        fetch_one(MB - 4, "ovf_top");
        for (int k = 0; k < 6; k++) fetch_one(rand_pc(MB), "ovf_f");
        fetch_idle("ovf_idle");

        do_reload(0, "rl_mid");
        img = '{8'hA1, 8'hA2, 8'hA3};
        load_image(img, 0, 1, "part");
        do_reset("rst_mid");
        img = '{8'h37, 8'h15, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        load_image(img, 1, 0, "after_rst");
        fetch_one(0, "ar_pc0");
        check("ar_pc0_const", instruction, 32'h0000_1537);
        fetch_one(4, "ar_pc4");
        fetch_one(MB - 4, "ar_old");
        fetch_idle("ar_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
